demux1_16_buf: RTL and testbench

Registered 1-to-16 demultiplexer with per-channel valid/ready handshakes: the write-side counterpart of the 16:1 bus select mux. A single producer presents a data word and a 4-bit destination select. The block steers the word into one of sixteen 1-deep holding buffers, and each buffer is drained independently by its consumer. It sits between the internal bus driver and the register/peripheral write ports, so back-pressure on one destination never corrupts another.

---
 rtl/demux1_16_buf.sv | 74 +++++++
 tb/tb_demux1_16_buf.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_16_buf.sv
// demux1_16_buf: registered 1:16 demux with sixteen 1-deep valid/ready buffers.
// Define DEMUX_STATS_EN to add the 16-bit wrapping acc_count output.
module demux1_16_buf #(
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_sel,
    input  logic [DATA_W-1:0]      in_data,
    output logic [15:0]            out_valid,
    input  logic [15:0]            out_ready,
    output logic [16*DATA_W-1:0]   out_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]            acc_count
`endif
);

    logic [15:0]       full;
    logic [DATA_W-1:0] data_q [16];
    logic              acc;
    logic [15:0]       load;
    logic [15:0]       drn;

    // Ready looks only at the selected channel, never at in_valid.
    assign in_ready = ~full[in_sel] | out_ready[in_sel];
    assign acc      = in_valid & in_ready;
    assign drn      = full & out_ready;

    always_comb begin
        load = '0;
        if (acc) begin
            load[in_sel] = 1'b1;
        end
    end

    // A load wins over a drain on the same channel: that is the bubble-free refill.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            full <= '0;
            for (int i = 0; i < 16; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (load[i]) begin
                    data_q[i] <= in_data;
                    full[i]   <= 1'b1;
                end else if (drn[i]) begin
                    full[i]   <= 1'b0;
                end
            end
        end
    end

    assign out_valid = full;

    for (genvar g = 0; g < 16; g++) begin : g_out
        assign out_data[g*DATA_W +: DATA_W] = data_q[g];
    end

`ifdef DEMUX_STATS_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            acc_count <= '0;
        end else if (acc) begin
            acc_count <= acc_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux1_16_buf.sv
// Self-checking bench for demux1_16_buf against a per-channel queue model.
// Build with DEMUX_STATS_EN defined to also exercise acc_count.
module tb_demux1_16_buf;

    logic         clk;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_sel;
    logic [31:0]  in_data;
    logic [15:0]  out_valid;
    logic [15:0]  out_ready;
    logic [511:0] out_data;
`ifdef DEMUX_STATS_EN
    logic [15:0]  acc_count;
`endif

    int checks = 0;
    int failures = 0;

    // Model: each channel is a queue of words handed over but not yet taken.
    logic [31:0] mq [16][$];
    logic [15:0] macc;

    demux1_16_buf #(.DATA_W(32)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX_STATS_EN
        ,
        .acc_count (acc_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mq[i].delete();
        macc = '0;
    endtask

    // One clock: drive at edge+1, sample ready at edge+3, advance model at edge.
    task automatic cycle(input logic v, input logic [3:0] s,
                         input logic [31:0] d, input logic [15:0] r,
                         output logic rdy_obs, output logic rdy_exp);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #2;
        rdy_obs = in_ready;
        rdy_exp = (mq[s].size() == 0) || r[s];
        @(posedge clk);
        for (int i = 0; i < 16; i++)
            if (r[i] && mq[i].size() != 0) void'(mq[i].pop_front());
        if (v && rdy_exp) begin
            mq[s].push_back(d);
            macc = macc + 16'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_sel = 0; in_data = 0; out_ready = 0;
        clr = 1'b1;
        #1;
        checks++;
        if (out_valid !== 16'h0000) begin
            failures++;
            $display("FAIL reset_valid got=%h exp=0000", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
`ifdef DEMUX_STATS_EN
        checks++;
        if (acc_count !== 16'h0000) begin
            failures++;
            $display("FAIL reset_count got=%h exp=0000", acc_count);
        end
`endif
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
    endtask

    task automatic test_basic();
        logic ro, re;
        cycle(1, 4'd5, 32'hDEADBEEF, 16'h0000, ro, re);
        checks++;
        if (out_valid !== 16'h0020 || out_data[5*32 +: 32] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL basic_load got=%h/%h exp=0020/deadbeef",
                     out_valid, out_data[5*32 +: 32]);
        end
        cycle(0, 4'd0, 32'h0, 16'h0020, ro, re);
        checks++;
        if (out_valid !== 16'h0000) begin
            failures++;
            $display("FAIL basic_drain got=%h exp=0000", out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic ro, re;
        cycle(1, 4'd3, 32'hAAAA0003, 16'h0000, ro, re);
        cycle(1, 4'd3, 32'hBBBB0003, 16'h0000, ro, re);
        checks++;
        if (ro !== 1'b0 || out_data[3*32 +: 32] !== 32'hAAAA0003) begin
            failures++;
            $display("FAIL bp_blocked ready=%b data=%h exp=0/aaaa0003",
                     ro, out_data[3*32 +: 32]);
        end
        cycle(1, 4'd4, 32'hCCCC0004, 16'h0000, ro, re);
        checks++;
        if (ro !== 1'b1 || out_valid !== 16'h0018 ||
            out_data[4*32 +: 32] !== 32'hCCCC0004) begin
            failures++;
            $display("FAIL bp_other ready=%b valid=%h data=%h exp=1/0018/cccc0004",
                     ro, out_valid, out_data[4*32 +: 32]);
        end
        cycle(0, 4'd0, 32'h0, 16'hFFFF, ro, re);
    endtask

    task automatic test_passthrough();
        logic ro, re;
        int bad;
        cycle(1, 4'd7, 32'h1, 16'h0000, ro, re);
        cycle(1, 4'd7, 32'h2, 16'h0080, ro, re);
        checks++;
        if (ro !== 1'b1 || out_valid[7] !== 1'b1 || out_data[7*32 +: 32] !== 32'h2) begin
            failures++;
            $display("FAIL pass_refill ready=%b valid=%b data=%h exp=1/1/2",
                     ro, out_valid[7], out_data[7*32 +: 32]);
        end
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1, 4'd7, 32'h100 + k, 16'h0080, ro, re);
            if (ro !== 1'b1 || out_valid[7] !== 1'b1 ||
                out_data[7*32 +: 32] !== 32'h100 + k) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL pass_stream bad_cycles=%0d exp=0", bad);
        end
        cycle(0, 4'd0, 32'h0, 16'hFFFF, ro, re);
    endtask

    task automatic test_all_channels();
        logic ro, re;
        int bad;
        for (int i = 0; i < 16; i++) cycle(1, 4'(i), 32'(i), 16'h0000, ro, re);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (out_data[i*32 +: 32] !== 32'(i)) bad++;
        checks++;
        if (out_valid !== 16'hFFFF || bad != 0) begin
            failures++;
            $display("FAIL all_fill valid=%h bad_slices=%0d exp=ffff/0", out_valid, bad);
        end
        cycle(0, 4'd0, 32'h0, 16'hFFFF, ro, re);
        checks++;
        if (out_valid !== 16'h0000) begin
            failures++;
            $display("FAIL all_drain got=%h exp=0000", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic ro, re;
        cycle(1, 4'd0, 32'h11111111, 16'h0000, ro, re);
        cycle(1, 4'd9, 32'h99999999, 16'h0000, ro, re);
        cycle(1, 4'd15, 32'hFFFF000F, 16'h0000, ro, re);
        in_valid = 1; in_sel = 4'd2; in_data = 32'h22222222; out_ready = 0;
        #2;
        clr = 1'b1;
        #1;
        checks++;
        if (out_valid !== 16'h0000 || out_data !== '0) begin
            failures++;
            $display("FAIL midrst_async valid=%h data_nonzero=%b exp=0000/0",
                     out_valid, out_data != '0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 16'h0000 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_held valid=%h ready=%b exp=0000/1", out_valid, in_ready);
        end
        clr = 1'b0;
        model_clear();
        cycle(0, 4'd2, 32'h0, 16'h0000, ro, re);
        checks++;
        if (out_valid !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_idle got=%h exp=0000", out_valid);
        end
        cycle(1, 4'd9, 32'h5A5A5A5A, 16'h0000, ro, re);
        checks++;
        if (out_valid !== 16'h0200 || out_data[9*32 +: 32] !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL midrst_next valid=%h data=%h exp=0200/5a5a5a5a",
                     out_valid, out_data[9*32 +: 32]);
        end
        cycle(0, 4'd0, 32'h0, 16'hFFFF, ro, re);
    endtask

    task automatic test_random();
        logic ro, re;
        logic pv;
        logic [3:0] ps;
        logic [31:0] pd;
        logic [15:0] r, ev;
        int bad_rdy, bad_v, bad_d;
        pv = 0; ps = 0; pd = 0;
        bad_rdy = 0; bad_v = 0; bad_d = 0;
        for (int n = 0; n < 500; n++) begin
            if (!pv && ($urandom % 4) != 0) begin
                pv = 1;
                ps = 4'($urandom_range(0, 15));
                pd = $urandom;
            end
            r = 16'($urandom) & 16'($urandom);
            cycle(pv, ps, pd, r, ro, re);
            if (ro !== re) bad_rdy++;
            if (pv && re) pv = 0;
            ev = '0;
            for (int i = 0; i < 16; i++) begin
                if (mq[i].size() != 0) begin
                    ev[i] = 1'b1;
                    if (out_data[i*32 +: 32] !== mq[i][0]) bad_d++;
                end
            end
            if (out_valid !== ev) bad_v++;
        end
        checks++;
        if (bad_rdy != 0) begin
            failures++;
            $display("FAIL rand_ready bad_cycles=%0d exp=0", bad_rdy);
        end
        checks++;
        if (bad_v != 0) begin
            failures++;
            $display("FAIL rand_valid bad_cycles=%0d exp=0", bad_v);
        end
        checks++;
        if (bad_d != 0) begin
            failures++;
            $display("FAIL rand_data bad_slices=%0d exp=0", bad_d);
        end
`ifdef DEMUX_STATS_EN
        checks++;
        if (acc_count !== macc) begin
            failures++;
            $display("FAIL rand_count got=%h exp=%h", acc_count, macc);
        end
`endif
        cycle(0, 4'd0, 32'h0, 16'hFFFF, ro, re);
    endtask

`ifdef DEMUX_STATS_EN
    task automatic test_stats();
        logic ro, re;
        clr = 1'b1;
        #1;
        clr = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        for (int k = 0; k < 65537; k++) cycle(1, 4'd0, 32'(k), 16'h0001, ro, re);
        checks++;
        if (acc_count !== 16'h0001 || macc !== 16'h0001) begin
            failures++;
            $display("FAIL stats_wrap got=%h exp=0001", acc_count);
        end
        clr = 1'b1;
        #1;
        checks++;
        if (acc_count !== 16'h0000) begin
            failures++;
            $display("FAIL stats_reset got=%h exp=0000", acc_count);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
    endtask
`endif

    initial begin
        clr = 1'b1;
        in_valid = 0; in_sel = 0; in_data = 0; out_ready = 0;
        macc = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_passthrough();
        test_all_channels();
        test_mid_reset();
        test_random();
`ifdef DEMUX_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
